// File: rtl/run_monitor.sv
// run_monitor: run controller and trace recorder for processor simulation benches.
// Samples the core's debug outputs every clock while running, counts run cycles
// and retirements, keeps a circular trace of the last TRACE_DEPTH retirements,
// and halts (done=1) on a halt instruction, a stalled PC or a cycle timeout.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   i_enable          run gate; low pauses counting and sampling
//   i_dbg_instr       core debug instruction
//   i_dbg_pc          core debug PC
//   i_dbg_result      core debug result
//   i_trace_rd_idx    trace read index, 0 = oldest valid entry
//   o_trace_rd_pc     PC of selected entry (0 if index out of range)
//   o_trace_rd_instr  instruction of selected entry (0 if index out of range)
//   o_trace_rd_result result of selected entry (0 if index out of range)
//   o_trace_count     valid trace entries, saturates at TRACE_DEPTH
//   o_cycle_count     RUN cycles with enable high
//   o_retire_count    retirements recorded (wraps)
//   o_state           00 IDLE, 01 RUN, 10 HALTED
//   o_done            high iff HALTED
//   o_halt_reason     00 none, 01 halt instr, 10 stall, 11 timeout
module run_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MAX_CYCLES  = 120,
  parameter int unsigned     STALL_LIMIT = 4,
  parameter int unsigned     TRACE_DEPTH = 8,
  parameter logic [XLEN-1:0] HALT_INSTR  = 32'h00100073
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic [XLEN-1:0]                i_dbg_instr,
  input  logic [XLEN-1:0]                i_dbg_pc,
  input  logic [XLEN-1:0]                i_dbg_result,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_rd_idx,
  output logic [XLEN-1:0]                o_trace_rd_pc,
  output logic [XLEN-1:0]                o_trace_rd_instr,
  output logic [XLEN-1:0]                o_trace_rd_result,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_count,
  output logic [31:0]                    o_cycle_count,
  output logic [31:0]                    o_retire_count,
  output logic [1:0]                     o_state,
  output logic                           o_done,
  output logic [1:0]                     o_halt_reason
);

  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int TCNT_W  = PTR_W + 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    R_NONE    = 2'b00,
    R_INSTR   = 2'b01,
    R_STALL   = 2'b10,
    R_TIMEOUT = 2'b11
  } reason_t;

  state_t              r_state, w_next_state;
  reason_t             r_halt_reason, w_halt_reason;
  logic [31:0]         r_cycle_count;
  logic [31:0]         r_retire_count;
  logic [TCNT_W-1:0]   r_trace_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [XLEN-1:0]     r_prev_pc;
  logic                r_prev_valid;

  logic [XLEN-1:0]     r_trace_pc     [TRACE_DEPTH];
  logic [XLEN-1:0]     r_trace_instr  [TRACE_DEPTH];
  logic [XLEN-1:0]     r_trace_result [TRACE_DEPTH];

  logic                w_sample;
  logic                w_retire;
  logic [STALL_W-1:0]  w_stall_next;
  logic [31:0]         w_cycle_next;
  logic [PTR_W-1:0]    w_rd_phys;
  logic                w_rd_valid;

  // A sample is taken only while running with the gate open; a paused cycle
  // touches nothing, so it can neither count nor look like a stall.
  assign w_sample     = (r_state == S_RUN) && i_enable;
  assign w_retire     = !r_prev_valid || (i_dbg_pc != r_prev_pc);
  assign w_stall_next = w_retire ? STALL_W'(1) : r_stall_cnt + STALL_W'(1);
  assign w_cycle_next = r_cycle_count + 32'd1;

  // Next-state and halt reason. Halt checks look at the updated counters so
  // the halt lands on the same edge as the sample that triggers it.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_halt_reason = r_halt_reason;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (i_enable) begin
          if (i_dbg_instr == HALT_INSTR) begin
            w_next_state  = S_HALTED;
            w_halt_reason = R_INSTR;
          end else if (w_stall_next == STALL_W'(STALL_LIMIT)) begin
            w_next_state  = S_HALTED;
            w_halt_reason = R_STALL;
          end else if (w_cycle_next == 32'(MAX_CYCLES)) begin
            w_next_state  = S_HALTED;
            w_halt_reason = R_TIMEOUT;
          end
        end
      end
      default: begin
        // HALTED is sticky until reset.
        w_next_state = r_state;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_halt_reason <= R_NONE;
    end else begin
      r_state       <= w_next_state;
      r_halt_reason <= w_halt_reason;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count  <= '0;
      r_retire_count <= '0;
      r_trace_count  <= '0;
      r_wr_ptr       <= '0;
      r_stall_cnt    <= '0;
      r_prev_pc      <= '0;
      r_prev_valid   <= 1'b0;
    end else if (w_sample) begin
      r_cycle_count <= w_cycle_next;
      r_stall_cnt   <= w_stall_next;
      r_prev_pc     <= i_dbg_pc;
      r_prev_valid  <= 1'b1;
      if (w_retire) begin
        // Power-of-two depth: the pointer wraps by natural overflow.
        r_wr_ptr       <= r_wr_ptr + PTR_W'(1);
        r_retire_count <= r_retire_count + 32'd1;
        if (r_trace_count != TCNT_W'(TRACE_DEPTH)) begin
          r_trace_count <= r_trace_count + TCNT_W'(1);
        end
      end
    end
  end

  // NOTE: trace storage has no reset; entries beyond trace_count are never
  // presented, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst && w_sample && w_retire) begin
      r_trace_pc[r_wr_ptr]     <= i_dbg_pc;
      r_trace_instr[r_wr_ptr]  <= i_dbg_instr;
      r_trace_result[r_wr_ptr] <= i_dbg_result;
    end
  end

  // Oldest valid entry sits trace_count slots behind the write pointer. When
  // saturated the low bits of trace_count are zero, so oldest == wr_ptr.
  assign w_rd_phys  = r_wr_ptr - r_trace_count[PTR_W-1:0] + i_trace_rd_idx;
  assign w_rd_valid = {1'b0, i_trace_rd_idx} < r_trace_count;

  always_comb begin
    o_trace_rd_pc     = '0;
    o_trace_rd_instr  = '0;
    o_trace_rd_result = '0;
    if (w_rd_valid) begin
      o_trace_rd_pc     = r_trace_pc[w_rd_phys];
      o_trace_rd_instr  = r_trace_instr[w_rd_phys];
      o_trace_rd_result = r_trace_result[w_rd_phys];
    end
  end

  assign o_trace_count  = r_trace_count;
  assign o_cycle_count  = r_cycle_count;
  assign o_retire_count = r_retire_count;
  assign o_state        = r_state;
  assign o_done         = (r_state == S_HALTED);
  assign o_halt_reason  = r_halt_reason;

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesisable run controller and trace recorder for processor simulation benches; replaces a fixed-time stop with parametrised halt detection.
- Samples the core's debug outputs (instruction, PC, result) every clock.
- Counts cycles and retirements and keeps a circular trace of the last TRACE_DEPTH retired instructions.
- Raises done with a halt reason on ebreak, PC stall or cycle timeout; the bench ends simulation on done.

Parameters:
XLEN, 32, width of debug instruction/PC/result buses
MAX_CYCLES, 120, RUN cycles before timeout halt (>=1)
STALL_LIMIT, 4, consecutive cycles with unchanged PC that trigger stall halt (>=2)
TRACE_DEPTH, 8, trace entries kept; power of two, >=2
HALT_INSTR, 32'h00100073, instruction encoding treated as halt (ebreak)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  run gate; low pauses counting and sampling
dbg_instr  in  XLEN  core debug instruction
dbg_pc  in  XLEN  core debug PC
dbg_result  in  XLEN  core debug result
trace_rd_idx  in  log2(TRACE_DEPTH)  read index, 0 = oldest valid entry
trace_rd_pc  out  XLEN  PC of selected entry
trace_rd_instr  out  XLEN  instruction of selected entry
trace_rd_result  out  XLEN  result of selected entry
trace_count  out  log2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
cycle_count  out  32  RUN cycles with enable high
retire_count  out  32  retirements recorded, non-saturating, wraps at 2^32
state  out  2  00 IDLE, 01 RUN, 10 HALTED
done  out  1  high iff state==HALTED
halt_reason  out  2  00 none, 01 halt instr, 10 stall, 11 timeout

Behaviour:
- Reset at clk edge with rst=1:
  - state=IDLE; all counters, trace_count, write pointer, stall counter, halt_reason and done = 0.
  - prev_valid=0; trace storage contents don't-care.
  - rst overrides every other event, including mid-RUN and in HALTED.
- IDLE:
  - Nothing is sampled.
  - enable=1 moves to RUN next edge; the first RUN sample is taken on the following edge.
- RUN, enable=0: all state frozen. A pause does not count as a stall cycle.
- RUN, enable=1, per edge:
  - cycle_count += 1.
  - Retire when prev_valid=0 or dbg_pc != prev_pc:
    - write {dbg_pc, dbg_instr, dbg_result} at wr_ptr;
    - wr_ptr = (wr_ptr+1) mod TRACE_DEPTH;
    - trace_count += 1, saturating at TRACE_DEPTH (oldest entry overwritten on wrap);
    - retire_count += 1; stall counter = 1.
  - Otherwise stall counter += 1.
  - prev_pc = dbg_pc; prev_valid = 1.
- Halt checks use the same sample and take effect on that edge (next state HALTED):
  - (a) dbg_instr == HALT_INSTR: the entry is still recorded, reason 01.
  - (b) updated stall counter == STALL_LIMIT: reason 10.
  - (c) updated cycle_count == MAX_CYCLES: reason 11.
  - Priority when simultaneous: a > b > c.
- HALTED:
  - Sticky until rst; counters and trace are frozen regardless of enable.
  - Trace remains readable.
- Trace read is combinational:
  - physical index = (wr_ptr - trace_count + trace_rd_idx) mod TRACE_DEPTH.
  - trace_rd_idx >= trace_count drives all three read outputs to 0.
- Outputs are registered except the trace read data and done (decoded from state).
- Widths: all pointer arithmetic is modulo TRACE_DEPTH; cycle_count compares in 32 bits.

Test Plan:
- Straight-line run, defaults:
  - Stimulus: PCs 0,4,8,C then 10 with dbg_instr=00100073.
  - Required: HALTED one edge after the ebreak sample; halt_reason=01, retire_count=5, cycle_count=5, trace_count=5.
  - Required: idx0 pc=0, idx4 pc=10.
- Stall:
  - Stimulus: PC 0,4,8 then 8 held.
  - Required: halt after 3 further cycles at 8 (stall counter reaches 4); halt_reason=10, retire_count=3, cycle_count=6.
- Timeout, MAX_CYCLES=20:
  - Stimulus: PC incrementing by 4 each cycle, no ebreak.
  - Required: halt on the 20th RUN cycle; halt_reason=11, cycle_count=20, retire_count=20.
  - Required: trace_count=8, idx0 pc=0x30 (12*4), idx7 pc=0x4C, idx beyond count n/a (saturated).
- Wrap/read-out-of-range:
  - Stimulus: 10 retirements with PCs 0..0x24, then inspect the trace.
  - Required: trace_count=8, idx0 pc=8, idx7 pc=0x24; with trace_count=3 and idx=5, outputs are 0.
- Enable pause and simultaneity:
  - Stimulus: enable low for 5 cycles with PC held.
  - Required: no stall and cycle_count unchanged.
  - Stimulus: ebreak on the MAX_CYCLES-th cycle.
  - Required: halt_reason=01.
- Reset mid-run:
  - Stimulus: assert rst in RUN after 7 cycles.
  - Required: next edge state=IDLE, all counts 0, done=0; after re-enable the first sample is recorded as a retire even if the PC matches the pre-reset PC.
